sram_1r1w: RTL

SRAM_1R1W -- requirements
Module: sram_1r1w

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_1r1w_array.sv | 35 +++
 rtl/sram_1r1w.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1-read/1-write SRAM.
// Optional feature macro: SRAM_1R1W_BYPASS_EN (same-address write-to-read bypass).
package sram_pkg;

  // Controller states: INIT sweeps zeros through the array, READY serves accesses
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Address width for a given depth; never less than one bit
  function automatic int addr_width(input int depth);
    int aw_s;
    aw_s = $clog2(depth);
    if (aw_s < 1) begin
      aw_s = 1;
    end else begin
      aw_s = aw_s;
    end
    return aw_s;
  endfunction

endpackage

// File: rtl/sram_1r1w_array.sv
// Storage array with one lane-masked synchronous write port and one
// asynchronous read port. Holds no reset: contents are only cleared by
// the controller's INIT sweep.
module sram_1r1w_array #(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8,
  parameter int AW        = 6,
  localparam int NL       = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NL-1:0]    wmask,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Masked write: only the enabled lanes of the addressed entry change
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < NL; i++) begin
        if (wmask[i]) begin
          mem_r[waddr][i*MASK_GRAN +: MASK_GRAN] <= wdata[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sram_1r1w.sv
// 1-read/1-write SRAM wrapper: clears the array after reset, then serves
// masked writes and registered (latency-1) reads.
// Optional macro SRAM_1R1W_BYPASS_EN: a same-address read/write returns the
// new data in written lanes; without it the read returns the old entry.
module sram_1r1w
  import sram_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8,
  localparam int AW       = addr_width(DEPTH),
  localparam int NL       = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [NL-1:0]    W0_mask,
  output logic             init_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           state_r, state_next_s;
  logic [AW-1:0]    init_ptr_r;
  logic             init_done_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;

  logic             arr_we_s;
  logic [AW-1:0]    arr_waddr_s;
  logic [WIDTH-1:0] arr_wdata_s;
  logic [NL-1:0]    arr_wmask_s;
  logic [WIDTH-1:0] rd_raw_s;
  logic [WIDTH-1:0] rd_next_s;
  logic             r_in_range_s;
  logic             w_in_range_s;

  // Out-of-range addresses only exist for non-power-of-two depths
  assign r_in_range_s = (32'(R0_addr) < 32'(DEPTH));
  assign w_in_range_s = (32'(W0_addr) < 32'(DEPTH));

  sram_1r1w_array #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN),
    .AW        (AW)
  ) u_array (
    .clock (clock),
    .we    (arr_we_s),
    .waddr (arr_waddr_s),
    .wdata (arr_wdata_s),
    .wmask (arr_wmask_s),
    .raddr (R0_addr),
    .rdata (rd_raw_s)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: leave INIT once the last entry has been cleared
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_ptr_r == LAST_IDX) begin
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_READY: state_next_s = ST_READY;
      default:  state_next_s = ST_INIT;
    endcase
  end

  // FSM outputs: array write port driven by the sweep in INIT, by W0 in READY
  always_comb begin
    arr_we_s    = 1'b0;
    arr_waddr_s = init_ptr_r;
    arr_wdata_s = {WIDTH{1'b0}};
    arr_wmask_s = {NL{1'b1}};
    case (state_r)
      ST_INIT: begin
        arr_we_s    = 1'b1;
        arr_waddr_s = init_ptr_r;
        arr_wdata_s = {WIDTH{1'b0}};
        arr_wmask_s = {NL{1'b1}};
      end
      ST_READY: begin
        arr_we_s    = W0_en & w_in_range_s;
        arr_waddr_s = W0_addr;
        arr_wdata_s = W0_data;
        arr_wmask_s = W0_mask;
      end
      default: begin
        arr_we_s    = 1'b0;
        arr_waddr_s = init_ptr_r;
        arr_wdata_s = {WIDTH{1'b0}};
        arr_wmask_s = {NL{1'b1}};
      end
    endcase
  end

  // Sweep pointer: advances once per INIT cycle and parks on the last entry
  always_ff @(posedge clock) begin
    if (reset) begin
      init_ptr_r <= {AW{1'b0}};
    end else if ((state_r == ST_INIT) && (init_ptr_r != LAST_IDX)) begin
      init_ptr_r <= init_ptr_r + AW'(1'b1);
    end else begin
      init_ptr_r <= init_ptr_r;
    end
  end

  // init_done rises together with the entry into READY
  always_ff @(posedge clock) begin
    if (reset) begin
      init_done_r <= 1'b0;
    end else begin
      init_done_r <= (state_next_s == ST_READY);
    end
  end

`ifdef SRAM_1R1W_BYPASS_EN
  logic collide_s;
  assign collide_s = W0_en & w_in_range_s & (W0_addr == R0_addr);
`endif

  // Read data selection: zeros out of range, optional lane bypass on collision
  always_comb begin
    rd_next_s = {WIDTH{1'b0}};
    if (r_in_range_s) begin
`ifdef SRAM_1R1W_BYPASS_EN
      if (collide_s) begin
        for (int i = 0; i < NL; i++) begin
          if (W0_mask[i]) begin
            rd_next_s[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
          end else begin
            rd_next_s[i*MASK_GRAN +: MASK_GRAN] = rd_raw_s[i*MASK_GRAN +: MASK_GRAN];
          end
        end
      end else begin
        rd_next_s = rd_raw_s;
      end
`else
      rd_next_s = rd_raw_s;
`endif
    end else begin
      rd_next_s = {WIDTH{1'b0}};
    end
  end

  // Read output registers: capture on accepted reads, hold data otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_r  <= {WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else if ((state_r == ST_READY) && R0_en) begin
      rd_data_r  <= rd_next_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_data_r  <= rd_data_r;
      rd_valid_r <= 1'b0;
    end
  end

  assign R0_data   = rd_data_r;
  assign R0_valid  = rd_valid_r;
  assign init_done = init_done_r;

endmodule
